// File: rtl/rev_logic_reduce_pkg.sv
// rev_pkg: shared definitions for the reversible logic-reduction unit.
// Holds the op encoding, the reduction-FSM state type and the per-op
// identity value used to seed the accumulator at the start of a group.
// Optional feature macro used by the top level: REV_GARBAGE_OUT_EN.
package rev_pkg;

  // Op encoding: bit 0 drives the HNG C input, bit 1 selects R over S.
  typedef logic [1:0] op_t;

  localparam op_t REV_AND  = 2'b00;
  localparam op_t REV_OR   = 2'b01;
  localparam op_t REV_XOR  = 2'b10;
  localparam op_t REV_XNOR = 2'b11;

  // Reduction FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Identity bit of the cross-beat reduction for an op; replicate it
  // across the datapath width to get the identity word. AND reduces
  // with all-ones; OR, XOR and XNOR reduce with zero.
  function automatic logic rev_identity_bit(input op_t op);
    return (op == REV_AND);
  endfunction

endpackage

// File: rtl/rev_logic_reduce_hng_cell.sv
// rev_hng_cell: one-bit HNG reversible gate with D tied to 0.
// S = (A^B)&C ^ A&B  -> AND when C=0, OR when C=1
// R = A^B^C          -> XOR when C=0, XNOR when C=1
// The pass-through P/Q lines of the full gate are not brought out.
module rev_hng_cell
  import rev_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic r
);

  logic w_ab;

  assign w_ab = a ^ b;
  assign s    = (w_ab & c) ^ (a & b);
  assign r    = w_ab ^ c;

endmodule

// File: rtl/rev_logic_reduce.sv
// rev_logic_reduce: WIDTH-bit array of HNG cells computing AND/OR/XOR/XNOR
// per beat, reduced over LEN consecutive beats into one registered result
// with valid/ready handshakes on both sides.
// Optional feature: define REV_GARBAGE_OUT_EN to expose the unselected HNG
// line of the final beat (out_garb) and a saturating garbage-bit counter
// (garb_cnt). With the macro undefined those ports do not exist and the
// functional outputs are unchanged.
module rev_logic_reduce
  import rev_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_op
`ifdef REV_GARBAGE_OUT_EN
  ,
  output logic [WIDTH-1:0] out_garb,
  output logic [15:0]      garb_cnt
`endif
);

  // Beat counter is at least one bit wide so LEN=1 still has a register.
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  // Cross-beat reduction: AND folds with &, OR with |, XOR/XNOR with ^.
  function automatic logic [WIDTH-1:0] f_combine(
    input op_t              o,
    input logic [WIDTH-1:0] acc,
    input logic [WIDTH-1:0] v
  );
    logic [WIDTH-1:0] res;
    case (o)
      REV_AND: res = acc & v;
      REV_OR:  res = acc | v;
      default: res = acc ^ v;
    endcase
    return res;
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  op_t              r_op;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  op_t              r_out_op;

  logic             w_first;
  op_t              w_op;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] w_acc_base;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_beat;
  logic             w_last;

  // The op is taken from the port only on the first beat of a group;
  // later beats use the latched copy so a mid-group change is ignored.
  assign w_first = (r_cnt == '0);
  assign w_op    = w_first ? op_t'(op) : r_op;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      rev_hng_cell u_cell (
        .a (in_a[gi]),
        .b (in_b[gi]),
        .c (w_op[0]),
        .s (w_s[gi]),
        .r (w_r[gi])
      );
    end
  endgenerate

  assign w_sel = w_op[1] ? w_r : w_s;

  // A fresh group starts from the op's identity, otherwise from the
  // running accumulator.
  assign w_acc_base = w_first ? {WIDTH{rev_identity_bit(w_op)}} : r_acc;
  assign w_acc_next = f_combine(w_op, w_acc_base, w_sel);

  // A beat presented together with clr is dropped.
  assign in_ready = !r_out_valid || out_ready;
  assign w_beat   = in_valid && in_ready && !clr;
  assign w_last   = w_beat && (r_cnt == LAST_CNT);

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_op    = r_out_op;

  // Reduction FSM with beat counter, accumulator and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_op        <= REV_AND;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_op    <= REV_AND;
    end else begin
      // clr discards the partial group but leaves a held result alone.
      if (clr) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else if (w_beat) begin
        if (w_first) begin
          r_op <= w_op;
        end
        if (w_last) begin
          r_cnt <= '0;
          r_acc <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_acc <= w_acc_next;
        end
      end

      // A last beat may land in the same cycle the held result leaves,
      // in which case out_valid simply stays high with the new value.
      if (w_last) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_acc_next;
        r_out_op    <= w_op;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_last) begin
            r_state <= ST_HOLD;
          end else if (w_beat) begin
            r_state <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (w_last) begin
            r_state <= ST_HOLD;
          end else if (clr) begin
            r_state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (w_last) begin
            r_state <= ST_HOLD;
          end else if (out_ready) begin
            r_state <= w_beat ? ST_ACC : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef REV_GARBAGE_OUT_EN
  localparam logic [16:0] GARB_STEP = 17'(WIDTH);

  logic [WIDTH-1:0] w_unsel;
  logic [16:0]      w_garb_sum;
  logic [WIDTH-1:0] r_out_garb;
  logic [15:0]      r_garb_cnt;

  assign w_unsel    = w_op[1] ? w_s : w_r;
  assign w_garb_sum = {1'b0, r_garb_cnt} + GARB_STEP;
  assign out_garb   = r_out_garb;
  assign garb_cnt   = r_garb_cnt;

  // Garbage line of the final beat travels with the result; the counter
  // adds WIDTH per accepted beat and saturates, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_garb <= '0;
      r_garb_cnt <= '0;
    end else begin
      if (w_last) begin
        r_out_garb <= w_unsel;
      end
      if (w_beat) begin
        r_garb_cnt <= w_garb_sum[16] ? 16'hFFFF : w_garb_sum[15:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_rev_logic_reduce.sv
// Bench for rev_logic_reduce: one LEN=4 instance and one LEN=1 instance,
// directed scenarios plus a randomized run against a group-level model.
// Honours REV_GARBAGE_OUT_EN when defined.
module tb_rev_logic_reduce;

  localparam int W  = 8;
  localparam int L0 = 4;
  localparam int L1 = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       clr  [2];
  logic       iv   [2];
  logic       ordy [2];
  logic [1:0] iop  [2];
  logic [7:0] ia   [2];
  logic [7:0] ib   [2];
  logic       ir   [2];
  logic       ov   [2];
  logic [7:0] od   [2];
  logic [1:0] oop  [2];
`ifdef REV_GARBAGE_OUT_EN
  logic [7:0]  og [2];
  logic [15:0] gc [2];
`endif

  rev_logic_reduce #(.WIDTH(W), .LEN(L0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .op(iop[0]), .in_a(ia[0]), .in_b(ib[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_data(od[0]), .out_op(oop[0])
`ifdef REV_GARBAGE_OUT_EN
    , .out_garb(og[0]), .garb_cnt(gc[0])
`endif
  );

  rev_logic_reduce #(.WIDTH(W), .LEN(L1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .op(iop[1]), .in_a(ia[1]), .in_b(ib[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_data(od[1]), .out_op(oop[1])
`ifdef REV_GARBAGE_OUT_EN
    , .out_garb(og[1]), .garb_cnt(gc[1])
`endif
  );

  int vectors = 0;
  int errors  = 0;

  // Group-level reference model state.
  bit         m_ov    [2];
  logic [7:0] m_od    [2];
  logic [1:0] m_oop   [2];
  logic [1:0] m_op    [2];
  int         m_cnt   [2];
  logic [7:0] m_beats [2][4];
  logic [7:0] m_og    [2];
  int         m_gc    [2];

  function automatic logic [7:0] beat_val(logic [1:0] o, logic [7:0] a, logic [7:0] b);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  // The HNG line the op does not select: logic ops leave XOR/XNOR behind,
  // parity ops leave AND/OR behind.
  function automatic logic [7:0] garb_val(logic [1:0] o, logic [7:0] a, logic [7:0] b);
    case (o)
      2'b00:   return a ^ b;
      2'b01:   return ~(a ^ b);
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic int len_of(int k);
    return (k == 0) ? L0 : L1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ov[k] = 1'b0; m_od[k] = 8'h00; m_oop[k] = 2'b00; m_op[k] = 2'b00;
      m_cnt[k] = 0; m_og[k] = 8'h00; m_gc[k] = 0;
    end
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      clr[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b1; iop[k] = 2'b00;
      ia[k] = 8'h00; ib[k] = 8'h00;
    end
  endtask

  // Advance one clock and the model alongside; returns at posedge + 1.
  task automatic tick();
    bit         hs [2];
    logic [7:0] res;
    for (int k = 0; k < 2; k++) hs[k] = iv[k] && (!m_ov[k] || ordy[k]) && !clr[k];
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (m_ov[k] && ordy[k]) m_ov[k] = 1'b0;
      if (clr[k]) begin
        m_cnt[k] = 0;
      end else if (hs[k]) begin
        if (m_cnt[k] == 0) m_op[k] = iop[k];
        m_beats[k][m_cnt[k]] = beat_val(m_op[k], ia[k], ib[k]);
        m_gc[k] = (m_gc[k] + W > 65535) ? 65535 : m_gc[k] + W;
        m_cnt[k]++;
        if (m_cnt[k] == len_of(k)) begin
          res = m_beats[k][0];
          for (int j = 1; j < m_cnt[k]; j++) begin
            case (m_op[k])
              2'b00:   res = res & m_beats[k][j];
              2'b01:   res = res | m_beats[k][j];
              default: res = res ^ m_beats[k][j];
            endcase
          end
          m_ov[k]  = 1'b1;
          m_od[k]  = res;
          m_oop[k] = m_op[k];
          m_og[k]  = garb_val(m_op[k], ia[k], ib[k]);
          m_cnt[k] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #3;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (ov[k] !== 1'b0 || od[k] !== 8'h00 || oop[k] !== 2'b00) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got valid=%b data=%h op=%b, want 0/00/00", k, ov[k], od[k], oop[k]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (ir[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_in_ready dut%0d: got %b, want 1", k, ir[k]);
      end
    end
  endtask

  task automatic test_or();
    logic [7:0] pat [4];
    pat = '{8'h01, 8'h02, 8'h04, 8'h08};
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1'b1; iop[0] = 2'b01; ia[0] = pat[i]; ib[0] = pat[i] & 8'($urandom);
      tick();
      vectors++;
      if (i < 3 && ov[0] !== 1'b0) begin
        errors++;
        $display("FAIL or_early_valid beat%0d: got %b, want 0", i, ov[0]);
      end
    end
    vectors++;
    if (ov[0] !== 1'b1 || od[0] !== 8'h0F || oop[0] !== 2'b01) begin
      errors++;
      $display("FAIL or_result: got valid=%b data=%h op=%b, want 1/0f/01", ov[0], od[0], oop[0]);
    end
    iv[0] = 1'b0;
    tick();
    vectors++;
    if (ov[0] !== 1'b0) begin
      errors++;
      $display("FAIL or_single_pulse: got valid=%b, want 0", ov[0]);
    end
  endtask

  task automatic test_and_opchange();
    logic [7:0] bs [4];
    bs = '{8'hF0, 8'h3C, 8'hFF, 8'hFC};
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1'b1; iop[0] = (i == 0) ? 2'b00 : 2'b10; ia[0] = 8'hFF; ib[0] = bs[i];
      tick();
    end
    vectors++;
    if (ov[0] !== 1'b1 || od[0] !== 8'h30 || oop[0] !== 2'b00) begin
      errors++;
      $display("FAIL and_opchange: got valid=%b data=%h op=%b, want 1/30/00", ov[0], od[0], oop[0]);
    end
`ifdef REV_GARBAGE_OUT_EN
    vectors++;
    if (og[0] !== 8'h03) begin
      errors++;
      $display("FAIL and_garb: got %h, want 03", og[0]);
    end
`endif
    iv[0] = 1'b0;
    tick();
  endtask

  task automatic test_xnor();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1'b1; iop[0] = 2'b11; ia[0] = 8'h00; ib[0] = 8'h00;
      tick();
    end
    vectors++;
    if (ov[0] !== 1'b1 || od[0] !== 8'h00 || oop[0] !== 2'b11) begin
      errors++;
      $display("FAIL xnor_result: got valid=%b data=%h op=%b, want 1/00/11", ov[0], od[0], oop[0]);
    end
    iv[0] = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_or;
    exp_or = 8'h00;
    idle_inputs();
    ordy[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1'b1; iop[0] = 2'b01; ia[0] = 8'($urandom); ib[0] = 8'($urandom);
      exp_or = exp_or | ia[0] | ib[0];
      #1;
      vectors++;
      if (ir[0] !== 1'b1) begin
        errors++;
        $display("FAIL bp_ready_beat%0d: got %b, want 1", i, ir[0]);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      iop[0] = 2'b10; ia[0] = 8'($urandom); ib[0] = 8'($urandom);
      #1;
      vectors++;
      if (ir[0] !== 1'b0 || ov[0] !== 1'b1 || od[0] !== exp_or || oop[0] !== 2'b01) begin
        errors++;
        $display("FAIL bp_hold cyc%0d: got ready=%b valid=%b data=%h op=%b, want 0/1/%h/01",
                 i, ir[0], ov[0], od[0], oop[0], exp_or);
      end
      tick();
    end
    ordy[0] = 1'b1;
    tick();
    vectors++;
    if (ov[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got valid=%b, want 0", ov[0]);
    end
    for (int i = 0; i < 3; i++) begin
      iop[0] = 2'b00; ia[0] = 8'($urandom); ib[0] = 8'($urandom);
      tick();
    end
    vectors++;
    if (ov[0] !== 1'b1 || od[0] !== m_od[0] || oop[0] !== 2'b10) begin
      errors++;
      $display("FAIL bp_next_group: got valid=%b data=%h op=%b, want 1/%h/10", ov[0], od[0], oop[0], m_od[0]);
    end
    iv[0] = 1'b0;
    tick();
  endtask

  task automatic test_clr();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      iv[0] = 1'b1; iop[0] = 2'b01; ia[0] = 8'h0F; ib[0] = 8'h00;
      tick();
    end
    clr[0] = 1'b1; ia[0] = 8'hFF;
    tick();
    clr[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1'b1; iop[0] = 2'b01; ia[0] = 8'h10; ib[0] = 8'h00;
      tick();
      vectors++;
      if (i < 3 && ov[0] !== 1'b0) begin
        errors++;
        $display("FAIL clr_early_valid beat%0d: got %b, want 0", i, ov[0]);
      end
    end
    vectors++;
    if (ov[0] !== 1'b1 || od[0] !== 8'h10) begin
      errors++;
      $display("FAIL clr_result: got valid=%b data=%h, want 1/10", ov[0], od[0]);
    end
    iv[0] = 1'b0;
    tick();
  endtask

  task automatic test_reset_hold();
    idle_inputs();
    ordy[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1'b1; iop[0] = 2'b10; ia[0] = 8'($urandom); ib[0] = 8'($urandom) | 8'h01;
      ia[0] = ia[0] & 8'hFE;
      tick();
    end
    iv[0] = 1'b0;
    vectors++;
    if (ov[0] !== 1'b1) begin
      errors++;
      $display("FAIL hold_before_reset: got valid=%b, want 1", ov[0]);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (ov[0] !== 1'b0 || od[0] !== 8'h00 || oop[0] !== 2'b00) begin
      errors++;
      $display("FAIL async_reset_hold: got valid=%b data=%h op=%b, want 0/00/00", ov[0], od[0], oop[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      iv[1] = 1'b1; iop[1] = 2'b10; ia[1] = 8'hAA; ib[1] = 8'h55;
      tick();
      vectors++;
      if (ov[1] !== 1'b1 || od[1] !== 8'hFF || oop[1] !== 2'b10) begin
        errors++;
        $display("FAIL b2b_xor cyc%0d: got valid=%b data=%h op=%b, want 1/ff/10", i, ov[1], od[1], oop[1]);
      end
`ifdef REV_GARBAGE_OUT_EN
      vectors++;
      if (og[1] !== 8'h00 || gc[1] !== 16'((i + 1) * 8)) begin
        errors++;
        $display("FAIL b2b_garb cyc%0d: got garb=%h cnt=%0d, want 00/%0d", i, og[1], gc[1], (i + 1) * 8);
      end
`endif
    end
    ordy[1] = 1'b0; ia[1] = 8'h0F; ib[1] = 8'h00;
    tick();
    vectors++;
    if (ov[1] !== 1'b1 || od[1] !== 8'hFF || ir[1] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stall: got valid=%b data=%h ready=%b, want 1/ff/0", ov[1], od[1], ir[1]);
    end
    ordy[1] = 1'b1;
    tick();
    vectors++;
    if (ov[1] !== 1'b1 || od[1] !== 8'h0F) begin
      errors++;
      $display("FAIL b2b_swap: got valid=%b data=%h, want 1/0f", ov[1], od[1]);
    end
    iv[1] = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k]   = ($urandom_range(0, 3) != 0);
        iop[k]  = 2'($urandom);
        ia[k]   = 8'($urandom);
        ib[k]   = 8'($urandom);
        ordy[k] = ($urandom_range(0, 2) != 0);
        clr[k]  = ($urandom_range(0, 39) == 0);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (ir[k] !== (!m_ov[k] || ordy[k])) begin
          errors++;
          $display("FAIL rand_ready dut%0d n=%0d: got %b, want %b", k, n, ir[k], (!m_ov[k] || ordy[k]));
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (ov[k] !== m_ov[k] || (m_ov[k] && (od[k] !== m_od[k] || oop[k] !== m_oop[k]))) begin
          errors++;
          $display("FAIL rand_out dut%0d n=%0d: got valid=%b data=%h op=%b, want %b/%h/%b",
                   k, n, ov[k], od[k], oop[k], m_ov[k], m_od[k], m_oop[k]);
        end
`ifdef REV_GARBAGE_OUT_EN
        vectors++;
        if ((m_ov[k] && og[k] !== m_og[k]) || gc[k] !== 16'(m_gc[k])) begin
          errors++;
          $display("FAIL rand_garb dut%0d n=%0d: got garb=%h cnt=%0d, want %h/%0d",
                   k, n, og[k], gc[k], m_og[k], m_gc[k]);
        end
`endif
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_or();
    test_and_opchange();
    test_xnor();
    test_backpressure();
    test_clr();
    test_reset_hold();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
